// File: rtl/ahb_subordinate_mem.sv
// ---------------------------------------------------------------------------
// ahb_subordinate_mem
//
// AHB subordinate backed by an internal word-addressed memory. It answers
// manager transfers with programmable wait states, the two-cycle ERROR
// response and byte-lane writes. It is the responder used while bringing
// up manager agents.
//
// Optional feature macro: AHB_SUB_EXCL_EN
//   Defined   : adds a single-entry exclusive monitor {valid, word, hmaster}
//               and drives hexokay.
//   Undefined : hexokay is tied to 0; hexcl and hmaster are ignored.
//
// Ports
//   hclk       in   clock
//   hresetn    in   asynchronous active-low reset
//   hselx      in   subordinate select
//   haddr      in   byte address (ADDR_WIDTH)
//   htrans     in   IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
//   hwrite     in   1 = write
//   hsize      in   transfer size, log2 bytes
//   hburst     in   burst type (ignored)
//   hprot      in   protection (ignored)
//   hwdata     in   write data, valid in the data phase (DATA_WIDTH)
//   hwstrb     in   write byte strobes (DATA_WIDTH/8)
//   hready     in   combined bus ready
//   hexcl      in   exclusive transfer
//   hmaster    in   manager ID (HMASTER_WIDTH)
//   hreadyout  out  subordinate ready
//   hresp      out  0 = OKAY, 1 = ERROR
//   hrdata     out  read data (DATA_WIDTH)
//   hexokay    out  exclusive OKAY
// ---------------------------------------------------------------------------
module ahb_subordinate_mem #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH     = 256,
  parameter int WAIT_STATES   = 0,
  parameter int HMASTER_WIDTH = 4
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic                     hselx,
  input  logic [ADDR_WIDTH-1:0]    haddr,
  input  logic [1:0]               htrans,
  input  logic                     hwrite,
  input  logic [2:0]               hsize,
  input  logic [2:0]               hburst,
  input  logic [3:0]               hprot,
  input  logic [DATA_WIDTH-1:0]    hwdata,
  input  logic [DATA_WIDTH/8-1:0]  hwstrb,
  input  logic                     hready,
  input  logic                     hexcl,
  input  logic [HMASTER_WIDTH-1:0] hmaster,
  output logic                     hreadyout,
  output logic                     hresp,
  output logic [DATA_WIDTH-1:0]    hrdata,
  output logic                     hexokay
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int BSHIFT = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_LAST = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  // Data-phase entry state for a transfer that passes the error check.
  localparam state_t S_OK_NEXT = (WAIT_STATES > 0) ? S_WAIT : S_LAST;

  // Bytes covered by a transfer of 2^size bytes starting at byte lane off.
  function automatic logic [STRB_W-1:0] lane_mask(input logic [BSHIFT-1:0] off,
                                                  input logic [2:0]        size);
    logic [STRB_W-1:0] m;
    int lo;
    int hi;
    lo = int'(off);
    hi = lo + (1 << size);
    for (int b = 0; b < STRB_W; b++) begin
      m[b] = (b >= lo) && (b < hi);
    end
    return m;
  endfunction

  // Any offset bit below the size boundary set means misaligned.
  function automatic logic misaligned(input logic [BSHIFT-1:0] off,
                                      input logic [2:0]        size);
    logic m;
    m = 1'b0;
    for (int i = 0; i < BSHIFT; i++) begin
      if ((i < int'(size)) && off[i]) m = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] base,
                                                        input logic [DATA_WIDTH-1:0] upd,
                                                        input logic [STRB_W-1:0]     be);
    logic [DATA_WIDTH-1:0] r;
    r = base;
    for (int b = 0; b < STRB_W; b++) begin
      if (be[b]) r[8*b +: 8] = upd[8*b +: 8];
    end
    return r;
  endfunction

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_wcnt;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_hrdata;

  logic [IDX_W-1:0]      r_idx_p0;
  logic                  r_write_p0;
  logic [STRB_W-1:0]     r_mask_p0;

  logic                  w_cap;
  logic                  w_cap_err;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [IDX_W-1:0]      w_haddr_idx;
  logic [BSHIFT-1:0]     w_off;
  logic                  w_commit;
  logic                  w_excl_fail;
  logic [STRB_W-1:0]     w_wr_be;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_rd_write;
  logic                  w_rd_load;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_hreadyout;
  logic                  w_hresp;
  logic                  w_unused;

  // ---- address phase: decode and error check ----
  assign w_word      = haddr >> BSHIFT;
  assign w_haddr_idx = w_word[IDX_W-1:0];
  assign w_off       = haddr[BSHIFT-1:0];

  // Captures are only taken while this subordinate is not stalling the bus.
  assign w_cap = ((r_state == S_IDLE) || (r_state == S_LAST) || (r_state == S_ERR2)) &&
                 hselx && hready && htrans[1];

  assign w_cap_err = (w_word >= ADDR_WIDTH'(MEM_DEPTH)) ||
                     misaligned(w_off, hsize) ||
                     (hsize > 3'(BSHIFT));

  always_ff @(posedge hclk) begin
    if (w_cap) begin
      r_idx_p0   <= w_haddr_idx;
      r_write_p0 <= hwrite;
      r_mask_p0  <= lane_mask(w_off, hsize);
    end
  end

  // ---- state machine ----
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_LAST, S_ERR2: w_next = w_cap ? (w_cap_err ? S_ERR1 : S_OK_NEXT) : S_IDLE;
      S_WAIT:                 w_next = (r_wcnt == 4'(WAIT_STATES)) ? S_LAST : S_WAIT;
      S_ERR1:                 w_next = S_ERR2;
      default:                w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_hreadyout = 1'b1;
    w_hresp     = 1'b0;
    case (r_state)
      S_WAIT: w_hreadyout = 1'b0;
      S_ERR1: begin
        w_hreadyout = 1'b0;
        w_hresp     = 1'b1;
      end
      S_ERR2: w_hresp = 1'b1;
      default: ;
    endcase
  end

  assign hreadyout = w_hreadyout;
  assign hresp     = w_hresp;

  // Wait counter runs 1..WAIT_STATES while in WAIT.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)                r_wcnt <= 4'd0;
    else if (w_next == S_WAIT)   r_wcnt <= (r_state == S_WAIT) ? r_wcnt + 4'd1 : 4'd1;
    else                         r_wcnt <= 4'd0;
  end

  // ---- data phase: write commit ----
  assign w_wr_be  = hwstrb & r_mask_p0;
  assign w_commit = (r_state == S_LAST) && r_write_p0 && !w_excl_fail;

  always_ff @(posedge hclk) begin
    if (w_commit) r_mem[r_idx_p0] <= merge_bytes(r_mem[r_idx_p0], hwdata, w_wr_be);
  end

  // ---- data phase: read load ----
  // Entering LAST from WAIT uses the captured transfer; otherwise LAST is
  // entered straight from a capture on this edge and uses the live bus.
  assign w_rd_idx   = (r_state == S_WAIT) ? r_idx_p0   : w_haddr_idx;
  assign w_rd_write = (r_state == S_WAIT) ? r_write_p0 : hwrite;
  assign w_rd_load  = (w_next == S_LAST) && !w_rd_write;

  // A write committing on the same edge to the same word is forwarded.
  assign w_rd_word = (w_commit && (r_idx_p0 == w_rd_idx)) ?
                     merge_bytes(r_mem[w_rd_idx], hwdata, w_wr_be) : r_mem[w_rd_idx];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)       r_hrdata <= '0;
    else if (w_rd_load) r_hrdata <= w_rd_word;
  end

  assign hrdata = r_hrdata;

`ifdef AHB_SUB_EXCL_EN
  // ---- exclusive monitor ----
  logic                     r_excl_p0;
  logic [HMASTER_WIDTH-1:0] r_master_p0;
  logic                     r_mon_vld;
  logic [IDX_W-1:0]         r_mon_idx;
  logic [HMASTER_WIDTH-1:0] r_mon_master;
  logic                     w_mon_match;

  always_ff @(posedge hclk) begin
    if (w_cap) begin
      r_excl_p0   <= hexcl;
      r_master_p0 <= hmaster;
    end
  end

  assign w_mon_match = r_mon_vld && (r_mon_idx == r_idx_p0) && (r_mon_master == r_master_p0);
  // A failed exclusive write still completes OKAY but never reaches memory.
  assign w_excl_fail = r_excl_p0 && r_write_p0 && !w_mon_match;
  assign hexokay     = (r_state == S_LAST) && r_excl_p0 && (!r_write_p0 || w_mon_match);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_mon_vld    <= 1'b0;
      r_mon_idx    <= '0;
      r_mon_master <= '0;
    end else if (r_state == S_LAST) begin
      if (r_excl_p0 && !r_write_p0) begin
        r_mon_vld    <= 1'b1;
        r_mon_idx    <= r_idx_p0;
        r_mon_master <= r_master_p0;
      end else if (w_commit && r_mon_vld && (r_mon_idx == r_idx_p0)) begin
        r_mon_vld <= 1'b0;
      end
    end
  end

  assign w_unused = ^{hburst, hprot, htrans[0]};
`else
  assign w_excl_fail = 1'b0;
  assign hexokay     = 1'b0;
  assign w_unused    = ^{hburst, hprot, htrans[0], hexcl, hmaster};
`endif

endmodule
